// File: rtl/pipe_stage_bank.sv
// rtl/pipe_stage_bank.sv - parametrised valid/ready pipeline register bank with hold, flush and perf counters
module pipe_stage_bank #(
    parameter int NUM_STAGES = 4,
    parameter int DATA_W     = 64,
    parameter int CNT_W      = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_W-1:0]                in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_W-1:0]                out_data,
    input  logic [NUM_STAGES-1:0]            hold,
    input  logic [NUM_STAGES-1:0]            flush,
    input  logic                             clr_cnt,
    output logic [NUM_STAGES-1:0]            stage_valid,
    output logic [NUM_STAGES*DATA_W-1:0]     stage_data,
    output logic [CNT_W-1:0]                 stall_cnt,
    output logic [CNT_W-1:0]                 flush_cnt,
    output logic [CNT_W-1:0]                 retire_cnt
);

    localparam int          PW      = $clog2(NUM_STAGES + 1);
    localparam int          LAST    = NUM_STAGES - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_STAGES-1:0]             v_q;
    logic [NUM_STAGES-1:0][DATA_W-1:0] data_q;
    logic [NUM_STAGES-1:0]             move;
    logic [NUM_STAGES-1:0]             accept;
    logic [NUM_STAGES-1:0]             src_valid;
    logic [NUM_STAGES-1:0][DATA_W-1:0] src_data;
    logic [PW-1:0]                     kill_cnt;
    logic [CNT_W+PW-1:0]               flush_sum;
    logic                              retire;

    // Ready chain: walk from the output back to the input so each stage sees its successor's accept.
    always_comb begin
        move   = '0;
        accept = '0;
        move[LAST]   = v_q[LAST] && !hold[LAST] && !flush[LAST] && out_ready;
        accept[LAST] = !v_q[LAST] || move[LAST];
        for (int i = LAST - 1; i >= 0; i--) begin
            move[i]   = v_q[i] && !hold[i] && !flush[i] && accept[i+1];
            accept[i] = !v_q[i] || move[i];
        end
    end

    // Each stage's source is the previous stage's move, stage 0 is fed from the upstream port.
    always_comb begin
        src_valid = {move[NUM_STAGES-2:0], in_valid};
        src_data  = {data_q[NUM_STAGES-2:0], in_data};
    end

    // Count valid entries killed by flush this cycle and form the widened saturating sum.
    always_comb begin
        kill_cnt = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            kill_cnt = kill_cnt + PW'(flush[i] & v_q[i]);
        end
        flush_sum = {{PW{1'b0}}, flush_cnt} + {{CNT_W{1'b0}}, kill_cnt};
    end

    assign in_ready    = accept[0];
    assign out_valid   = v_q[LAST] && !hold[LAST] && !flush[LAST];
    assign out_data    = data_q[LAST];
    assign stage_valid = v_q;
    assign stage_data  = data_q;
    assign retire      = out_valid && out_ready;

    // Stage registers: flush beats accept beats hold; bubbles leave the stored payload untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            data_q <= '0;
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (flush[i]) begin
                    v_q[i] <= 1'b0;
                end else if (accept[i]) begin
                    v_q[i] <= src_valid[i];
                    if (src_valid[i]) begin
                        data_q[i] <= src_data[i];
                    end
                end
            end
        end
    end

    // Saturating performance counters; clr_cnt overrides any increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (in_valid && !accept[0] && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (retire && retire_cnt != CNT_MAX) begin
                retire_cnt <= retire_cnt + 1'b1;
            end
            if (|flush_sum[CNT_W +: PW]) begin
                flush_cnt <= CNT_MAX;
            end else begin
                flush_cnt <= flush_sum[CNT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_bank.sv
// tb/tb_pipe_stage_bank.sv - directed scoreboard bench for pipe_stage_bank
module tb_pipe_stage_bank;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_data;
    logic [N-1:0]      hold = '0;
    logic [N-1:0]      flush = '0;
    logic              clr_cnt = 1'b0;
    logic [N-1:0]      stage_valid;
    logic [N*DW-1:0]   stage_data;
    logic [CW-1:0]     stall_cnt;
    logic [CW-1:0]     flush_cnt;
    logic [CW-1:0]     retire_cnt;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] sb[$];

    pipe_stage_bank #(.NUM_STAGES(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .hold(hold), .flush(flush), .clr_cnt(clr_cnt),
        .stage_valid(stage_valid), .stage_data(stage_data),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] sd(input int i);
        return stage_data[i*DW +: DW];
    endfunction

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        hold      = '0;
        flush     = '0;
        while ((sb.size() != 0 || stage_valid != '0) && n < 20) begin
            tick();
            n++;
        end
        chk("drain_in_time", 64'(n < 20), 64'd1);
        chk("sb_empty_after_drain", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard: every output handshake must match the oldest expected payload.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 64'(out_data), 64'hDEAD);
            end else begin
                chk("out_data", 64'(out_data), 64'(sb.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_sv[4];
        logic       pat[8];

        // Reset state
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_stage_valid", 64'(stage_valid), 64'd0);
        chk("rst_stage_data", 64'(stage_data), 64'd0);
        chk("rst_retire_cnt", 64'(retire_cnt), 64'd0);

        // Back-to-back stream 1..8, out_valid from cycle 4 to 11
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 8);
            in_data  = DW'(c + 1);
            if (c < 8) sb.push_back(DW'(c + 1));
            #1;
            chk("t1_out_valid", 64'(out_valid), 64'(c >= 4 && c < 12));
            tick();
        end
        chk("t1_retire_cnt", 64'(retire_cnt), 64'd8);
        chk("t1_stall_cnt", 64'(stall_cnt), 64'd0);

        // Backpressure: exactly 4 accepts then stall, then same-cycle ready on release
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        #1;
        chk("clr_retire_cnt", 64'(retire_cnt), 64'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_data = DW'(16'h10 + (c < 4 ? c : 4));
            if (c < 4) sb.push_back(in_data);
            #1;
            chk("t2_in_ready", 64'(in_ready), 64'(c < 4));
            chk("t2_stall_cnt", 64'(stall_cnt), 64'(c > 4 ? c - 4 : 0));
            tick();
        end
        out_ready = 1'b1;
        in_data   = 16'h14;
        sb.push_back(16'h14);
        #1;
        chk("t2_release_in_ready", 64'(in_ready), 64'd1);
        chk("t2_release_out_valid", 64'(out_valid), 64'd1);
        tick();
        in_valid = 1'b0;
        for (int c = 9; c < 14; c++) begin
            #1;
            chk("t2_drain_out_valid", 64'(out_valid), 64'(c <= 12));
            tick();
        end
        chk("t2_stall_final", 64'(stall_cnt), 64'd4);

        // Only stages 0 and 3 valid with out_ready=0: stage 0 item collapses to stage 2
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h31;
        sb.push_back(16'h31);
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        #1;
        chk("t3_sv_x_at_3", 64'(stage_valid), 64'b1000);
        in_valid = 1'b1;
        in_data  = 16'h32;
        sb.push_back(16'h32);
        tick();
        in_valid = 1'b0;
        exp_sv = '{4'b1001, 4'b1010, 4'b1100, 4'b1100};
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("t3_stage_valid", 64'(stage_valid), 64'(exp_sv[c]));
            chk("t3_stage3_data", 64'(sd(3)), 64'h31);
            chk("t3_in_ready", 64'(in_ready), 64'd1);
            tick();
        end
        drain();

        // Full pipe, hold[1] for two cycles: two bubbles, two idle output cycles
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_data = DW'(16'h41 + c);
            sb.push_back(in_data);
            tick();
        end
        #1;
        chk("t4_full", 64'(stage_valid), 64'b1111);
        hold      = 4'b0010;
        out_ready = 1'b1;
        in_data   = 16'h45;
        sb.push_back(16'h45);
        pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int h = 0; h < 8; h++) begin
            if (h == 2) hold = '0;
            if (h == 3) in_valid = 1'b0;
            #1;
            chk("t4_out_valid", 64'(out_valid), 64'(pat[h]));
            if (h < 3) chk("t4_in_ready", 64'(in_ready), 64'(h == 2));
            if (h == 1) begin
                chk("t4_sv_bubble", 64'(stage_valid), 64'b1011);
                chk("t4_s0_frozen", 64'(sd(0)), 64'h44);
                chk("t4_s1_frozen", 64'(sd(1)), 64'h43);
            end
            if (h == 2) chk("t4_sv_two_bubbles", 64'(stage_valid), 64'b0011);
            tick();
        end
        drain();

        // Flush stages 0 and 1 of a full pipe: only the two oldest retire
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_data = DW'(16'hD - c);
            if (c < 2) sb.push_back(in_data);
            tick();
        end
        in_valid = 1'b0;
        flush    = 4'b0011;
        #1;
        chk("t5_full", 64'(stage_valid), 64'b1111);
        chk("t5_flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = '0;
        #1;
        chk("t5_sv_after_flush", 64'(stage_valid), 64'b1100);
        chk("t5_flush_cnt", 64'(flush_cnt), 64'd2);
        drain();
        chk("t5_retire_cnt", 64'(retire_cnt), 64'd2);

        // flush[0] on an empty stage with in_valid: handshake completes, payload dropped
        out_ready = 1'b0;
        flush     = 4'b0001;
        in_valid  = 1'b1;
        in_data   = 16'hEE;
        #1;
        chk("t5_drop_in_ready", 64'(in_ready), 64'd1);
        tick();
        flush    = '0;
        in_valid = 1'b0;
        #1;
        chk("t5_drop_sv", 64'(stage_valid), 64'd0);
        chk("t5_drop_flush_cnt", 64'(flush_cnt), 64'd2);

        // flush[3] with out_ready=1: no handshake, no retire
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h77;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        #1;
        chk("t5_z_at_3", 64'(stage_valid), 64'b1000);
        flush     = 4'b1000;
        out_ready = 1'b1;
        #1;
        chk("t5_flush3_out_valid", 64'(out_valid), 64'd0);
        tick();
        flush = '0;
        #1;
        chk("t5_flush3_sv", 64'(stage_valid), 64'd0);
        chk("t5_flush3_retire", 64'(retire_cnt), 64'd0);
        chk("t5_flush3_flush_cnt", 64'(flush_cnt), 64'd1);

        // Stall counter saturation, clear, then mid-stream reset
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h99;
        for (int c = 0; c < 20; c++) tick();
        chk("t6_stall_sat", 64'(stall_cnt), 64'd15);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        #1;
        chk("t6_clr_stall", 64'(stall_cnt), 64'd0);
        chk("t6_clr_flush", 64'(flush_cnt), 64'd0);
        chk("t6_still_full", 64'(stage_valid), 64'b1111);
        tick();
        chk("t6_stall_resume", 64'(stall_cnt), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_rst_sv", 64'(stage_valid), 64'd0);
        chk("t6_rst_stall", 64'(stall_cnt), 64'd0);
        chk("t6_rst_in_ready", 64'(in_ready), 64'd1);
        chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        tick();

        chk("sb_empty_final", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_bank.md
Name: pipe_stage_bank

Overview:
- Parametrised bank of NUM_STAGES pipeline registers that replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block.
- Each stage holds a DATA_W payload and a valid bit. Stages move with valid/ready backpressure, and empty slots collapse forward.
- Per-stage hold inserts bubbles (e.g. load-use); per-stage flush kills entries (e.g. taken branch).
- Saturating stall/flush/retire counters support performance debug.

Parameters:
- NUM_STAGES, 4, number of register stages (>=2)
- DATA_W, 64, payload width per stage (packed control + data fields)
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high (clock clk)
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage 0 can accept this cycle
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  stage NUM_STAGES-1 presents payload
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  stage NUM_STAGES-1 payload
- hold  in  NUM_STAGES  hold[i]: stage i must not pass its contents forward
- flush  in  NUM_STAGES  flush[i]: kill stage i contents at next edge
- clr_cnt  in  1  synchronous clear of all counters
- stage_valid  out  NUM_STAGES  valid bit of every stage
- stage_data  out  NUM_STAGES*DATA_W  all stage payloads, stage i at bits [i*DATA_W +: DATA_W]
- stall_cnt  out  CNT_W  cycles with in_valid && !in_ready
- flush_cnt  out  CNT_W  valid entries killed by flush
- retire_cnt  out  CNT_W  out_valid && out_ready handshakes

Behaviour:
- Reset: on rst at a clock edge, all stage valids, stage data and counters go to 0. Every other input is ignored that cycle, including mid-stream. After reset, in_ready=1 and out_valid=0.
- Definitions (combinational, per cycle). Let v[i] be the valid bit of stage i. A stage's contents leave only when the next stage can take them:
  - accept[N-1] = !v[N-1] || move[N-1]
  - accept[i] = !v[i] || move[i], for i < N-1
  - move[N-1] = v[N-1] && !hold[N-1] && !flush[N-1] && out_ready
  - move[i] = v[i] && !hold[i] && !flush[i] && accept[i+1], for i < N-1
- The ready chain is combinational from out_ready to in_ready; no skid buffer.
- Outputs:
  - in_ready = accept[0]
  - out_valid = v[N-1] && !hold[N-1] && !flush[N-1]
  - out_data = data[N-1]
- Next state for stage i, in priority order:
  1. flush[i]: v[i] <= 0. Any transfer into stage i this cycle is consumed and dropped; the upstream side still sees the handshake complete.
  2. accept[i]: v[i] <= src_valid and data[i] <= src_data, but only when src_valid is 1. The source is in_valid/in_data for stage 0 and move[i-1]/data[i-1] otherwise.
  3. Otherwise stage i holds.
- Bubble data: a bubble (src_valid=0) leaves data[i] unchanged. Payload is meaningful only when the valid bit is 1.
- Hold semantics: with hold[i] set, stage i freezes. Stages before i freeze once full. Stage i+1 receives bubbles if it advances.
- Latency and ordering: a payload accepted in cycle t appears on out_valid in cycle t+NUM_STAGES when nothing blocks it. Order is strictly preserved and nothing is duplicated.
- Simultaneous hold[i] and flush[i]: flush wins.
- flush[N-1] with out_ready=1: no handshake occurs and retire_cnt does not increment.
- Counters: saturate at all-ones, never wrap.
  - flush_cnt adds popcount(flush & v) each cycle, saturating.
  - clr_cnt zeroes all counters at the next edge and overrides any increment that cycle. rst also clears them.

Test Plan:
- Reset, then 8 back-to-back inputs 0x1..0x8 with out_ready=1, NUM_STAGES=4 -> first out_valid 4 cycles after the first accept; outputs 0x1..0x8 on consecutive cycles; retire_cnt=8; stall_cnt=0.
- out_ready=0 with in_valid held 1 -> exactly 4 accepts, then in_ready=0; stall_cnt increments each further cycle. Raising out_ready -> in-order drain, one item per cycle, with in_ready=1 in the same cycle.
- Only stages 0 and 3 valid, out_ready=0 -> the stage 0 item advances one stage per cycle until it reaches stage 2; stage 3 stays unchanged; in_ready stays 1.
- Full pipe, hold[1]=1 for 2 cycles, out_ready=1 -> stage 2 receives 2 bubbles; stages 0 and 1 are frozen; in_ready=0. After release, ordering is intact and there are exactly 2 idle out cycles.
- Full pipe A,B,C,D (D in stage 3), flush=4'b0011 for one cycle -> C and D retire, A and B never appear, flush_cnt=2. Repeat with flush[0] and in_valid=1 in the same cycle -> the input is dropped.
- CNT_W=4, out_ready=0 for 20 cycles -> stall_cnt saturates at 15. clr_cnt -> 0. rst asserted mid-stream -> all stage_valid=0 and counters 0 on the next cycle.
